acq_fifo: RTL
=============

Name: acq_fifo

Overview:
Parametrised synchronous sample FIFO for the acquisition datapath. It buffers ADC words between the converter interface and the readout/transfer logic. It is the successor to the existing fixed 24x32 FIFO and adds the following:
- exact full/empty at DEPTH
- fill level output
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow flags
- synchronous flush
- selectable first-word-fall-through (FWFT) read mode

Parameters:
DATA_W, 24, data word width in bits
ADDR_W, 5, pointer width; DEPTH = 2**ADDR_W words (32 by default)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst_a  in  1  asynchronous reset, active-high
clr  in  1  synchronous flush: empties the FIFO
wr_en  in  1  write request
data_in  in  DATA_W  write data
rd_en  in  1  read request (FWFT=1: pop the head word)
data_out  out  DATA_W  read data
valid  out  1  data_out holds a valid word (meaning depends on FWFT, see Behaviour)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh
level  out  ADDR_W+1  number of stored words, 0..DEPTH
af_thresh  in  ADDR_W+1  almost-full threshold, quasi-static
ae_thresh  in  ADDR_W+1  almost-empty threshold, quasi-static
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset values (rst_a=1, asynchronous):
  - wr_ptr = rd_ptr = 0, level = 0
  - data_out = 0, valid = 0, overflow = underflow = 0
  - empty = 1, full = 0
  - almost_full and almost_empty follow the thresholds combinationally from level = 0
  - Memory contents are not reset.
- Storage: DEPTH x DATA_W register array. The memory row width is DATA_W, not ADDR_W.
- Pointers are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Write accepted (wa) = wr_en & !full. On wa: mem[wr_ptr] <= data_in; wr_ptr++.
- Read accepted (ra) = rd_en & !empty. On ra: rd_ptr++.
- Level update (registered):
  - +1 on wa & !ra
  - -1 on ra & !wa
  - unchanged on both or neither
- full, empty, almost_full and almost_empty are combinational from the registered level, so they change in the same cycle as level.
- Simultaneous requests:
  - When full: read accepted, write rejected, overflow set. The write is NOT accepted through the read.
  - When empty: write accepted, read rejected, underflow set. The word is not bypassed to the output.
- FWFT=0:
  - On ra, data_out <= mem[rd_ptr], so the word appears 1 cycle after the request.
  - valid is a 1-cycle pulse, registered as ra.
  - Otherwise data_out holds its last value; it is not zeroed when rd_en is low.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acknowledges the presented word, and the next word is visible the following cycle.
  - A word written into an empty FIFO is visible on data_out 1 cycle after the write, with valid = 1.
- Sticky error flags:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
  - err_clr clears both flags. If a new error occurs in the same cycle as err_clr, the set wins.
  - clr does not affect the error flags.
- clr:
  - Next cycle: wr_ptr = rd_ptr = level = 0 and valid = 0.
  - data_out holds (FWFT=0).
  - clr overrides wr_en/rd_en in the same cycle: nothing is written and no error is flagged.
- Threshold handling:
  - Thresholds are compared unsigned.
  - af_thresh = 0 forces almost_full = 1.
  - ae_thresh >= DEPTH forces almost_empty = 1.
- Reset mid-operation: asynchronous return to the reset values; any stored data is discarded.

Test Plan:
- Fill/drain, FWFT=0, DEPTH=32: write 0x000001..0x000020 over 32 cycles.
  - Required: full = 1, level = 32.
  - 33rd write sets overflow and leaves level = 32.
  - 32 reads return the words in order, each 1 cycle after rd_en, with valid pulses; then empty = 1.
  - 33rd read sets underflow.
- Wrap-around: repeat 3 passes of 20 writes followed by 20 reads.
  - Required: data order is preserved across the pointer wrap; level returns to 0 after each pass.
- Simultaneous read/write:
  - At level 10: level stays 10 and the read data is the oldest word.
  - At full: level goes to 31 and overflow = 1.
  - At empty: level goes to 1, underflow = 1, no valid pulse.
- Thresholds: af_thresh = 28, ae_thresh = 3, with writes one per cycle.
  - Required: almost_empty deasserts when level becomes 4; almost_full asserts when level becomes 28.
  - Reads reverse both transitions at the same levels.
- FWFT=1: write 0xABCDEF into an empty FIFO.
  - Required: data_out = 0xABCDEF and valid = 1 the next cycle with no rd_en.
  - After rd_en, empty = 1 and valid = 0.
- Flush, error clear and reset:
  - clr at level 17 together with wr_en: level = 0 next cycle and no write occurs.
  - err_clr clears both sticky flags.
  - rst_a pulsed mid-stream (not clock-aligned): all outputs take their reset values immediately.

Source files
------------

// File: rtl/acq_fifo.sv
// Parametrised acquisition sample FIFO with fill level, thresholds,
// sticky error flags, synchronous flush and optional FWFT read mode.
module acq_fifo #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;
  logic              r_udf;
  logic              w_wa;
  logic              w_ra;
  logic              w_ovf_set;
  logic              w_udf_set;

  assign full         = (r_level == L_DEPTH);
  assign empty        = (r_level == '0);
  assign almost_full  = (r_level >= af_thresh);
  assign almost_empty = (r_level <= ae_thresh);
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Flush masks both requests, so it also suppresses error flagging.
  assign w_wa      = wr_en & ~full & ~clr;
  assign w_ra      = rd_en & ~empty & ~clr;
  assign w_ovf_set = wr_en & full & ~clr;
  assign w_udf_set = rd_en & empty & ~clr;

  always_ff @(posedge clk) begin
    if (w_wa) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wa) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_ra) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_wa & ~w_ra) r_level <= r_level + 1'b1;
        else if (w_ra & ~w_wa) r_level <= r_level - 1'b1;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_udf_set) r_udf <= 1'b1;
      else if (err_clr) r_udf <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : r_mem[r_rd_ptr];
    assign valid    = ~empty;
  end else begin : g_reg
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_ra;
        if (w_ra) r_dout <= r_mem[r_rd_ptr];
      end
    end

    assign data_out = r_dout;
    assign valid    = r_valid;
  end

endmodule
